// File: rtl/chronologic_pkg.sv
// chronologic_pkg: shared types and constants for the chronologic monitor.
//   verdict_t  : per-edge outcome of one implication attempt
//   judge()    : maps enable/match/consequent onto a verdict
package chronologic_pkg;

    typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL} verdict_t;

    localparam int DELAY_DEF = 5;
    localparam int CNT_W_DEF = 16;
    localparam int DELAY_MAX = 64;

    // A disabled or unmatched attempt is vacuous; otherwise the consequent decides.
    function automatic verdict_t judge(input logic en, input logic match, input logic cons);
        if (!(en && match)) return V_NONE;
        return cons ? V_PASS : V_FAIL;
    endfunction

endpackage

// File: rtl/chronologic_hist.sv
// chronologic_hist: DELAY-deep shift register of sampled x.
//   clk, rst : clock, asynchronous active-high reset (clears history)
//   x_i      : sample shifted in each rising edge
//   tap_o    : oldest stage, i.e. x as sampled DELAY edges earlier
module chronologic_hist #(
    parameter int DELAY = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic x_i,
    output logic tap_o
);

    logic [DELAY-1:0] hist_q, hist_d;

    // Loop form keeps DELAY=1 legal (no [DELAY-2:0] slice).
    always_comb begin
        hist_d    = hist_q;
        hist_d[0] = x_i;
        for (int i = 1; i < DELAY; i++) hist_d[i] = hist_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= '0;
        else     hist_q <= hist_d;
    end

    assign tap_o = hist_q[DELAY-1];

endmodule

// File: rtl/chronologic.sv
// chronologic: on-chip checker for "x, then y DELAY cycles later, implies x && y".
//   clk, rst        : sampling clock, asynchronous active-high reset
//   en              : evaluation enable (history keeps shifting when low)
//   x, y            : monitored signals
//   pass, fail      : registered one-cycle verdict pulses
//   pass_cnt/fail_cnt : saturating event counters (tied to 0 unless
//                     CHRONOLOGIC_COUNT_EN is defined)
//   err_sticky      : set by the first fail, cleared only by reset
module chronologic
    import chronologic_pkg::*;
#(
    parameter int DELAY = DELAY_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             y,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky
);

    generate
        if (DELAY < 1 || DELAY > DELAY_MAX) begin : g_bad_delay
            $error("chronologic: DELAY out of range 1..DELAY_MAX");
        end
    endgenerate

    logic     x_old;
    verdict_t verdict_d, verdict_q;
    logic     err_d, err_q;

    chronologic_hist #(.DELAY(DELAY)) u_hist (
        .clk   (clk),
        .rst   (rst),
        .x_i   (x),
        .tap_o (x_old)
    );

    // Antecedent: x DELAY edges ago and y now; consequent: x && y now.
    assign verdict_d = judge(en, x_old & y, x & y);
    assign err_d     = err_q | (verdict_d == V_FAIL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verdict_q <= V_NONE;
            err_q     <= 1'b0;
        end else begin
            verdict_q <= verdict_d;
            err_q     <= err_d;
        end
    end

    assign pass       = (verdict_q == V_PASS);
    assign fail       = (verdict_q == V_FAIL);
    assign err_sticky = err_q;

`ifdef CHRONOLOGIC_COUNT_EN
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

    // Hold at all-ones instead of wrapping.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (verdict_d == V_PASS && !(&pass_cnt_q)) pass_cnt_d = pass_cnt_q + CNT_W'(1);
        if (verdict_d == V_FAIL && !(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`else
    assign pass_cnt = '0;
    assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_chronologic.sv
// tb_chronologic: three DUTs (DELAY=5/CNT_W=16, DELAY=5/CNT_W=4, DELAY=1/CNT_W=8)
// share one stimulus stream; a queue-based model of past x samples predicts
// every output, checked each cycle, plus directed literal checks.
module tb_chronologic;

`ifdef CHRONOLOGIC_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, x = 1'b0, y = 1'b0;

    logic [2:0]  p_o, f_o, e_o;
    logic [15:0] pc0, fc0;
    logic [3:0]  pc1, fc1;
    logic [7:0]  pc2, fc2;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    chronologic #(.DELAY(5), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .pass(p_o[0]), .fail(f_o[0]),
        .pass_cnt(pc0), .fail_cnt(fc0), .err_sticky(e_o[0]));
    chronologic #(.DELAY(5), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .pass(p_o[1]), .fail(f_o[1]),
        .pass_cnt(pc1), .fail_cnt(fc1), .err_sticky(e_o[1]));
    chronologic #(.DELAY(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .pass(p_o[2]), .fail(f_o[2]),
        .pass_cnt(pc2), .fail_cnt(fc2), .err_sticky(e_o[2]));

    // ---------------- reference model ----------------
    int D[3] = '{5, 5, 1};
    int W[3] = '{16, 4, 8};
    bit q[$];                       // q[0] = most recent past x sample
    bit e_pass[3] = '{0, 0, 0};
    bit e_fail[3] = '{0, 0, 0};
    bit e_err[3]  = '{0, 0, 0};
    int e_pc[3]   = '{0, 0, 0};
    int e_fc[3]   = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            for (int k = 0; k < 3; k++) begin
                e_pass[k] = 0; e_fail[k] = 0; e_err[k] = 0; e_pc[k] = 0; e_fc[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit m;
                m = (q.size() >= D[k]) && q[D[k]-1] && y;
                e_pass[k] = en && m && x;
                e_fail[k] = en && m && !x;
                if (e_fail[k]) e_err[k] = 1;
                if (CNT_ON && e_pass[k] && e_pc[k] < (1 << W[k]) - 1) e_pc[k]++;
                if (CNT_ON && e_fail[k] && e_fc[k] < (1 << W[k]) - 1) e_fc[k]++;
            end
            q.push_front(x);
            if (q.size() > 64) void'(q.pop_back());
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_pc(input int k);
        return (k == 0) ? 32'(pc0) : (k == 1) ? 32'(pc1) : 32'(pc2);
    endfunction
    function automatic logic [31:0] dut_fc(input int k);
        return (k == 0) ? 32'(fc0) : (k == 1) ? 32'(fc1) : 32'(fc2);
    endfunction

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("pass[%0d]", k), 32'(p_o[k]), 32'(e_pass[k]));
            chk($sformatf("fail[%0d]", k), 32'(f_o[k]), 32'(e_fail[k]));
            chk($sformatf("err[%0d]", k),  32'(e_o[k]), 32'(e_err[k]));
            chk($sformatf("pass_cnt[%0d]", k), dut_pc(k), 32'(e_pc[k]));
            chk($sformatf("fail_cnt[%0d]", k), dut_fc(k), 32'(e_fc[k]));
            chk($sformatf("excl[%0d]", k), 32'(p_o[k] & f_o[k]), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 2 time units after a rising edge; on return the outputs
    // reflect the verdict of the edge that sampled these inputs.
    task automatic step(input bit xv, input bit yv, input bit ev);
        x = xv; y = yv; en = ev;
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; x = 1'b0; y = 1'b0; en = 1'b1;
        #1;
        chk("rst_pass", 32'(p_o[0]), 32'd0);
        chk("rst_cnt",  32'(pc0), 32'd0);
        chk("rst_err",  32'(e_o[0]), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("init_fail", 32'(f_o[0]), 32'd0);
        rst = 1'b0;

        // Steady-high: first pass after edge 5, counters then step by one.
        for (int i = 0; i < 5; i++) step(1, 1, 1);
        chk("sh_nopass_e4", 32'(p_o[0]), 32'd0);
        step(1, 1, 1);
        chk("sh_pass_e5", 32'(p_o[0]), 32'd1);
        chk("sh_cnt_e5",  32'(pc0), CNT_ON ? 32'd1 : 32'd0);
        for (int i = 0; i < 20; i++) step(1, 1, 1);
        chk("sat_cnt4", 32'(pc1), CNT_ON ? 32'd15 : 32'd0);
        chk("sh_cnt16", 32'(pc0), CNT_ON ? 32'd21 : 32'd0);

        // Mid-run reset: outputs clear at once, pass returns after 5 new samples.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 1);
        chk("mr_nopass_e4", 32'(p_o[0]), 32'd0);
        step(1, 1, 1);
        chk("mr_pass_e5", 32'(p_o[0]), 32'd1);

        // Failing consequent, then sticky error survives later passes.
        do_reset();
        step(1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(0, 1, 1);
        chk("fc_fail", 32'(f_o[0]), 32'd1);
        chk("fc_err",  32'(e_o[0]), 32'd1);
        chk("fc_fcnt", 32'(fc0), CNT_ON ? 32'd1 : 32'd0);
        for (int i = 0; i < 6; i++) step(1, 1, 1);
        chk("fc_latepass", 32'(p_o[0]), 32'd1);
        chk("fc_err_hold", 32'(e_o[0]), 32'd1);

        // Vacuous.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 1);
        chk("vac_pcnt", 32'(pc0), 32'd0);

        // Delay boundary: y at 4 and 6 miss, y at 5 matches.
        do_reset();
        step(1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(1, 1, 1);
        chk("db_e4", 32'(p_o[0] | f_o[0]), 32'd0);
        step(0, 0, 1);
        chk("db_e5", 32'(p_o[0] | f_o[0]), 32'd0);
        step(1, 1, 1);
        chk("db_e6", 32'(p_o[0] | f_o[0]), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 1);
        step(1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(1, 1, 1);
        chk("db_match5", 32'(p_o[0]), 32'd1);

        // Randomized run with enable gaps and occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/chronologic.md
# chronologic

Synthesizable temporal-property checker for two single-bit monitored signals, `x` and `y`. Each cycle it evaluates the property "x, then y DELAY cycles later, implies x && y in that same later cycle" (overlapped implication). It emits registered pass/fail pulses and optional event counters. It sits beside a design as an on-chip monitor, mirroring a simulation assertion in silicon.

## Interface
- `DELAY`, default 5: cycle gap between antecedent `x` and antecedent `y`; legal range 1..64.
- `CNT_W`, default 16: width of the pass/fail counters.
- `clk` input 1: sampling clock; all sampling on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: evaluation enable; history still shifts when low.
- `x` input 1: monitored signal x.
- `y` input 1: monitored signal y.
- `pass` output 1: one-cycle pulse when the antecedent matched and the consequent held.
- `fail` output 1: one-cycle pulse when the antecedent matched and the consequent was false.
- `pass_cnt` output CNT_W: saturating count of pass events.
- `fail_cnt` output CNT_W: saturating count of fail events.
- `err_sticky` output 1: set on the first fail; cleared only by reset.

## Operation
- History: DELAY-deep shift register of sampled `x`. `xh[DELAY-1]` is the value of `x` DELAY edges earlier.
- Antecedent match at edge t requires `x(t-DELAY)==1 && y(t)==1`.
- Consequent at edge t requires `x(t)==1 && y(t)==1`; it is checked at the same edge as the match.
- Verdict per edge (only when `en==1`):
  - match and consequent true: PASS.
  - match and consequent false: FAIL.
  - no match: NONE (vacuous); no pulse, no count.
- `en==0`: verdict is NONE. History continues shifting, so evaluation resumes immediately when `en` returns to 1.
- Overlapping attempts are independent. Every edge starts a new attempt, so a pulse can occur on consecutive cycles.
- Counters increment by 1 per PASS/FAIL and saturate at all-ones; no wrap-around.
- `err_sticky` is set by any FAIL and stays set.

## Timing
- `pass`/`fail` are registered. A verdict computed at edge t appears after edge t and is valid for exactly one cycle.
- `pass` and `fail` are never high simultaneously.
- Counters and `err_sticky` update on the same edge that asserts the corresponding pulse.
- Reset values: `pass=0`, `fail=0`, `pass_cnt=0`, `fail_cnt=0`, `err_sticky=0`, history all 0.
- After reset deassertion, no match is possible until DELAY edges have sampled `x`, because history starts at 0 and only real samples fill it.
- Reset asserted mid-operation clears history and outputs immediately; in-flight attempts are discarded.

## Configuration
- `CHRONOLOGIC_COUNT_EN` defined: `pass_cnt`/`fail_cnt` registers and their saturation logic are built.
- `CHRONOLOGIC_COUNT_EN` undefined: counter ports remain but are tied to 0 and no counter flops exist.
- `pass`, `fail` and `err_sticky` behave the same with or without the macro.

## Structure
- Package `chronologic_pkg` holds:
  - `typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL} verdict_t`.
  - Constants `DELAY_DEF=5`, `CNT_W_DEF=16`, `DELAY_MAX=64`.
- Sub-module `chronologic_hist` contains the parameterized DELAY-deep shift register, with asynchronous reset.
- The top level holds match/consequent logic, verdict registers, counters and the sticky flag.
- An elaboration-time check rejects DELAY outside 1..DELAY_MAX.

## Test plan
- **Steady-high:** x=1, y=1 from cycle 0, DELAY=5. No pulse on cycles 0–5; `pass` is high every cycle after edge 5; `pass_cnt` increments by 1 per cycle; `fail` stays 0.
- **Failing consequent:** x=1 at cycle 0 only, y=1 at cycle 5, x=0 at cycle 5. `fail` pulses once after edge 5, `fail_cnt=1`, `err_sticky=1` and remains set through later passes.
- **Vacuous:** x=1, y=0 for 20 cycles. No pulses; both counters stay 0.
- **Delay boundary:** x pulse at cycle 0, y=1 with x=1 at cycle 4 and at cycle 6 (DELAY=5). No match at either cycle; only a y at cycle 5 matches.
- **Mid-run reset:** steady-high, then `rst` pulsed at cycle 10. Outputs are 0 immediately; the first `pass` after release occurs only after 5 new x samples.
- **Saturation (CNT_W=4, macro defined):** 20 consecutive passes. `pass_cnt` holds at 15.
